// File: rtl/rr_mux_arbiter_if.sv
// Shared serial-mux bus: four requester lanes in, one granted serial lane out.
interface rr_mux_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic       dout;
  logic       last;

  modport master (output req, din, input grant, sel, valid, dout, last);
  modport slave  (input req, din, output grant, sel, valid, dout, last);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner of a 4:1 bit-serial mux; grants bursts of up to BURST_LEN bits.
module rr_mux_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux_arbiter_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [1:0]       sel, ptr;
  logic [CNT_W-1:0] cnt;

  logic       busy, req_sel, at_max, rel, arb, found;
  logic [1:0] base, winner;

  assign busy    = (state == GRANT);
  assign req_sel = bus.req[sel];
  assign at_max  = (cnt == CNT_MAX);
  assign rel     = busy & (~req_sel | at_max);
  assign arb     = ~busy | rel;
  assign base    = rel ? sel + 2'd1 : ptr;

  // Data path is a pure combinational mux, qualified by the owner's request.
  assign bus.grant = busy ? (4'b0001 << sel) : 4'b0000;
  assign bus.sel   = sel;
  assign bus.valid = busy & req_sel;
  assign bus.dout  = bus.valid & bus.din[sel];
  assign bus.last  = bus.valid & at_max;

  // Scan from the farthest offset down so the nearest requester to base wins.
  always_comb begin
    found  = 1'b0;
    winner = base;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[base + 2'(k)]) begin
        found  = 1'b1;
        winner = base + 2'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else if (arb) begin
      if (found) begin
        state <= GRANT;
        sel   <= winner;
        ptr   <= winner + 2'd1;
        cnt   <= '0;
      end else begin
        state <= IDLE;
        ptr   <= base;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule
